// File: rtl/nec_ir_if.sv
// nec_ir_if: frame request and IR drive signals of the NEC transmitter
interface nec_ir_if;
    logic       start;
    logic [7:0] address;
    logic [7:0] command;
    logic       ir_tx;
    logic       ir_env_n;
    logic       busy;
    logic       done;
    modport master (output start, address, command, input ir_tx, ir_env_n, busy, done);
    modport slave (input start, address, command, output ir_tx, ir_env_n, busy, done);
endinterface

// File: rtl/nec_ir_transmitter.sv
// nec_ir_transmitter: NEC frame serialiser with carrier-modulated LED drive and loopback envelope
module nec_ir_transmitter #(
    parameter int UNIT_CYCLES    = 28125,
    parameter int CARRIER_PERIOD = 1316,
    parameter int CARRIER_HIGH   = 658
) (
    input logic     clk_50,
    input logic     reset,
    nec_ir_if.slave ir
);
    localparam int UW = $clog2(UNIT_CYCLES);
    localparam int CW = $clog2(CARRIER_PERIOD);
    localparam logic [UW-1:0] U_LAST = UW'(UNIT_CYCLES - 1);
    localparam logic [CW-1:0] C_LAST = CW'(CARRIER_PERIOD - 1);
    localparam logic [CW-1:0] C_HIGH = CW'(CARRIER_HIGH);

    typedef enum logic [2:0] {IDLE, LEAD_MARK, LEAD_SPACE, BIT_MARK, BIT_SPACE, STOP_MARK} state_t;

    state_t        state, state_d;
    logic [UW-1:0] uc, uc_d;
    logic [3:0]    un, un_d, last_un;
    logic [CW-1:0] cc, cc_d;
    logic [4:0]    bi, bi_d;
    logic [31:0]   sr, sr_d;
    logic          unit_end, state_end, mark_d;
    logic          tx_d, env_d, busy_d, done_d;

    always_ff @(posedge clk_50) begin
        if (reset) begin
            state       <= IDLE;
            uc          <= '0;
            un          <= '0;
            cc          <= '0;
            bi          <= '0;
            sr          <= '0;
            ir.ir_tx    <= 1'b0;
            ir.ir_env_n <= 1'b1;
            ir.busy     <= 1'b0;
            ir.done     <= 1'b0;
        end else begin
            state       <= state_d;
            uc          <= uc_d;
            un          <= un_d;
            cc          <= cc_d;
            bi          <= bi_d;
            sr          <= sr_d;
            ir.ir_tx    <= tx_d;
            ir.ir_env_n <= env_d;
            ir.busy     <= busy_d;
            ir.done     <= done_d;
        end
    end

    // last_un is the final unit index of the current state; a 1 bit carries a 3-unit space
    always_comb begin
        unit_end  = uc == U_LAST;
        last_un   = state == LEAD_MARK ? 4'd15 : state == LEAD_SPACE ? 4'd7 :
                    (state == BIT_SPACE && sr[0]) ? 4'd2 : 4'd0;
        state_end = unit_end && un == last_un;
        state_d   = state;
        sr_d      = sr;
        bi_d      = bi;
        case (state)
            IDLE: if (ir.start) begin
                state_d = LEAD_MARK;
                sr_d    = {~ir.command, ir.command, ~ir.address, ir.address};
                bi_d    = '0;
            end
            LEAD_MARK:  if (state_end) state_d = LEAD_SPACE;
            LEAD_SPACE: if (state_end) state_d = BIT_MARK;
            BIT_MARK:   if (state_end) state_d = BIT_SPACE;
            BIT_SPACE: if (state_end) begin
                state_d = bi == 5'd31 ? STOP_MARK : BIT_MARK;
                sr_d    = sr >> 1;
                bi_d    = bi + 5'd1;
            end
            STOP_MARK:  if (state_end) state_d = IDLE;
            default:    state_d = IDLE;
        endcase
        uc_d = (state == IDLE || state_d != state || unit_end) ? '0 : uc + 1'b1;
        un_d = (state == IDLE || state_d != state) ? '0 : un + 4'(unit_end);
        cc_d = (state_d != state || cc == C_LAST) ? '0 : cc + 1'b1;
    end

    // outputs are registered from next-state values so they line up with the state they describe
    always_comb begin
        mark_d = state_d == LEAD_MARK || state_d == BIT_MARK || state_d == STOP_MARK;
        tx_d   = mark_d && cc_d < C_HIGH;
        env_d  = !mark_d;
        busy_d = state_d != IDLE;
        done_d = state == STOP_MARK && state_d == IDLE;
    end
endmodule

// File: tb/tb_nec_ir_transmitter.sv
// tb_nec_ir_transmitter: randomized frame checks against a segment-level NEC model
module tb_nec_ir_transmitter;
    localparam int U  = 10;
    localparam int P  = 4;
    localparam int H  = 2;
    localparam int FL = 1210;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mpos;
    logic exp_env [FL];
    logic exp_tx  [FL];
    logic obs_env [FL];

    nec_ir_if ir ();

    nec_ir_transmitter #(.UNIT_CYCLES(U), .CARRIER_PERIOD(P), .CARRIER_HIGH(H)) dut (
        .clk_50(clk),
        .reset (reset),
        .ir    (ir)
    );

    always #5 clk = ~clk;

    task automatic add_seg(input logic mark, input int units);
        for (int j = 0; j < units * U; j++) begin
            if (mpos < FL) begin
                exp_env[mpos] = !mark;
                exp_tx[mpos]  = mark && (j % P) < H;
            end
            mpos++;
        end
    endtask

    task automatic build_model(input logic [7:0] a, input logic [7:0] c);
        logic [31:0] w;
        w    = {~c, c, ~a, a};
        mpos = 0;
        add_seg(1'b1, 16);
        add_seg(1'b0, 8);
        for (int b = 0; b < 32; b++) begin
            add_seg(1'b1, 1);
            add_seg(1'b0, w[b] ? 3 : 1);
        end
        add_seg(1'b1, 1);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called just after an edge with the DUT able to accept start on the next edge.
    task automatic test_frame(input logic [7:0] a, input logic [7:0] c, input bit keep, input bit disturb,
                              input string tag);
        logic [3:0]  o, e;
        logic [31:0] word;
        int          i, s;
        build_model(a, c);
        ir.address = a;
        ir.command = c;
        ir.start   = 1'b1;
        for (int k = 0; k <= FL; k++) begin
            step();
            if (k == 0 && !keep) ir.start = 1'b0;
            if (disturb && k == 600) begin
                ir.address = ~a;
                ir.command = ~c;
                ir.start   = 1'b1;
            end
            if (disturb && k == 601 && !keep) ir.start = 1'b0;
            o = {ir.ir_tx, ir.ir_env_n, ir.busy, ir.done};
            e = k < FL ? {exp_tx[k], exp_env[k], 2'b10} : 4'b0101;
            if (k < FL) obs_env[k] = ir.ir_env_n;
            n_cmp++;
            if (o !== e) begin
                n_bad++;
                $display("FAIL %s cycle t+%0d {tx,env_n,busy,done} got %b want %b", tag, k + 1, o, e);
            end
        end
        if (!keep) begin
            step();
            n_cmp++;
            if (ir.done !== 1'b0 || ir.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL %s after-done done=%b busy=%b want 0 0", tag, ir.done, ir.busy);
            end
        end
        word = '0;
        i = 240;
        for (int b = 0; b < 32; b++) begin
            while (i < FL && obs_env[i] == 1'b0) i++;
            s = 0;
            while (i < FL && obs_env[i] == 1'b1) begin
                s++;
                i++;
            end
            word[b] = s > 2 * U;
        end
        n_cmp++;
        if (word !== {~c, c, ~a, a}) begin
            n_bad++;
            $display("FAIL %s decoded word got %h want %h", tag, word, {~c, c, ~a, a});
        end
    endtask

    task automatic test_reset();
        for (int k = 0; k < 50; k++) begin
            step();
            n_cmp++;
            if ({ir.ir_tx, ir.ir_env_n, ir.busy, ir.done} !== 4'b0100) begin
                n_bad++;
                $display("FAIL reset_idle cycle %0d got %b want 0100", k,
                         {ir.ir_tx, ir.ir_env_n, ir.busy, ir.done});
            end
        end
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++)
            test_frame(8'($urandom), 8'($urandom), 1'b0, 1'b0, "random");
    endtask

    task automatic test_start_held();
        logic [7:0] a1, c1, a2, c2;
        a1 = 8'($urandom);
        c1 = 8'($urandom);
        a2 = 8'($urandom);
        c2 = 8'($urandom);
        test_frame(a1, c1, 1'b1, 1'b1, "held_first");
        test_frame(a2, c2, 1'b0, 1'b0, "held_second");
    endtask

    // zero data puts bit 12's space at frame cycles 570..599
    task automatic test_reset_mid();
        ir.address = 8'h00;
        ir.command = 8'h00;
        ir.start   = 1'b1;
        for (int k = 0; k <= 575; k++) begin
            step();
            ir.start = 1'b0;
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        n_cmp++;
        if ({ir.ir_tx, ir.ir_env_n, ir.busy, ir.done} !== 4'b0100) begin
            n_bad++;
            $display("FAIL reset_mid abort got %b want 0100", {ir.ir_tx, ir.ir_env_n, ir.busy, ir.done});
        end
        for (int k = 0; k < 30; k++) begin
            step();
            n_cmp++;
            if ({ir.ir_tx, ir.ir_env_n, ir.busy, ir.done} !== 4'b0100) begin
                n_bad++;
                $display("FAIL reset_mid quiet cycle %0d got %b want 0100", k,
                         {ir.ir_tx, ir.ir_env_n, ir.busy, ir.done});
            end
        end
        test_frame(8'($urandom), 8'($urandom), 1'b0, 1'b0, "after_reset");
    endtask

    initial begin
        ir.start   = 1'b0;
        ir.address = 8'h00;
        ir.command = 8'h00;
        repeat (3) step();
        reset = 1'b0;
        test_reset();
        test_frame(8'h00, 8'h00, 1'b0, 1'b0, "frame_a");
        test_frame(8'hA5, 8'h3C, 1'b0, 1'b0, "frame_b");
        test_random();
        test_start_held();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
